// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port between the pixel fetcher and its synchronous memory.
// The fetcher drives address and strobe; the memory returns data after a fixed latency.
interface vga_pixel_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_data
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel fetch: one word read per 16 pixels, bit select, colour map,
// with syncs carried through a delay line so rgb/hsync/vsync stay aligned.
module vga_pixel_fetch #(
  parameter int         MEM_LATENCY  = 1,
  parameter int         Y_TOP        = 80,
  parameter int         Y_BOT        = 479,
  parameter int         X_MAX        = 639,
  parameter logic [7:0] FG_COLOR     = 8'hFF,
  parameter logic [7:0] BG_COLOR     = 8'h00,
  parameter logic [7:0] BORDER_COLOR = 8'h03
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  input  logic                bright,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [15:0]         address,
  input  logic [3:0]          position,
  vga_pixel_fetch_if.master   mem,
  output logic [7:0]          rgb,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int          DEPTH = MEM_LATENCY + 1;
  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LO  = 11'(Y_TOP);
  localparam logic [10:0] Y_HI  = 11'(Y_BOT);

  typedef struct packed {
    logic [3:0] pos;
    logic       win;
    logic       fetch;
    logic       bright;
    logic       hs;
    logic       vs;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{pos: 4'd0, win: 1'b0, fetch: 1'b0,
                                    bright: 1'b0, hs: 1'b1, vs: 1'b1};

  logic        in_win_s;
  logic        fetch_s;
  logic        rd_en_r;
  logic [15:0] addr_r;
  logic        last_valid_r;
  stage_t      dly_r [DEPTH];
  stage_t      tail_s;
  logic [15:0] word_r;
  logic [15:0] word_sel_s;
  logic        bit_s;
  logic [7:0]  rgb_r;
  logic        hs_r;
  logic        vs_r;

  // Window test and read-suppression decision on the current pixel.
  always_comb begin
    in_win_s = bright && (x <= X_LIM) && (y >= Y_LO) && (y <= Y_HI);
    if (in_win_s) begin
      fetch_s = !last_valid_r || (address != addr_r);
    end else begin
      fetch_s = 1'b0;
    end
  end

  // Fetch stage: strobe once per new word; leaving the window forces the next fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_r      <= 1'b0;
      addr_r       <= 16'h0000;
      last_valid_r <= 1'b0;
    end else if (fetch_s) begin
      rd_en_r      <= 1'b1;
      addr_r       <= address;
      last_valid_r <= 1'b1;
    end else begin
      rd_en_r      <= 1'b0;
      last_valid_r <= last_valid_r && in_win_s;
    end
  end

  assign mem.mem_rd_en = rd_en_r;
  assign mem.mem_addr  = addr_r;

  // Delay line: last stage lines up with the cycle the read data arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dly_r[i] <= STAGE_IDLE;
      end
    end else begin
      dly_r[0] <= '{pos: position, win: in_win_s, fetch: fetch_s,
                    bright: bright, hs: hsync_in, vs: vsync_in};
      for (int i = 1; i < DEPTH; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign tail_s = dly_r[DEPTH-1];

  // Fresh data is used directly on its arrival cycle, the held copy after that.
  always_comb begin
    if (tail_s.fetch) begin
      word_sel_s = mem.mem_data;
    end else begin
      word_sel_s = word_r;
    end
    bit_s = word_sel_s[4'd15 - tail_s.pos];
  end

  // Word buffer holds the last fetched word for the remaining pixels of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r <= 16'h0000;
    end else if (tail_s.fetch) begin
      word_r <= mem.mem_data;
    end else begin
      word_r <= word_r;
    end
  end

  // Output stage: colour map and aligned syncs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r <= 8'h00;
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
    end else begin
      if (tail_s.win) begin
        rgb_r <= bit_s ? FG_COLOR : BG_COLOR;
      end else begin
        rgb_r <= tail_s.bright ? BORDER_COLOR : 8'h00;
      end
      hs_r <= tail_s.hs;
      vs_r <= tail_s.vs;
    end
  end

  assign rgb       = rgb_r;
  assign hsync_out = hs_r;
  assign vsync_out = vs_r;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Runs two fetchers (memory latency 1 and 3) on identical pixel streams against
// a framebuffer-level reference of what each pixel should look like.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        bright, hsync_in, vsync_in;
  logic [15:0] address;
  logic [3:0]  position;
  logic [7:0]  rgb1, rgb3;
  logic        hs1, vs1, hs3, vs3;

  always #5 clk = ~clk;

  vga_pixel_fetch_if mif1 ();
  vga_pixel_fetch_if mif3 ();

  vga_pixel_fetch #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .x(x), .y(y), .bright(bright),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .address(address),
    .position(position), .mem(mif1), .rgb(rgb1),
    .hsync_out(hs1), .vsync_out(vs1)
  );

  vga_pixel_fetch #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .x(x), .y(y), .bright(bright),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .address(address),
    .position(position), .mem(mif3), .rgb(rgb3),
    .hsync_out(hs3), .vsync_out(vs3)
  );

  // Framebuffer and synchronous memories; unread cycles return junk.
  logic [15:0] fb [65536];
  logic [15:0] p1 [1];
  logic [15:0] p3 [3];

  always @(posedge clk) begin
    p1[0] <= mif1.mem_rd_en ? fb[mif1.mem_addr] : 16'($urandom);
    p3[0] <= mif3.mem_rd_en ? fb[mif3.mem_addr] : 16'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign mif1.mem_data = p1[0];
  assign mif3.mem_data = p3[2];

  // Reference state: expected {rgb,hs,vs} per applied pixel, plus read bookkeeping.
  int          vectors = 0;
  int          errors  = 0;
  int          n       = 0;
  logic [9:0]  hist [8];
  logic        m_valid;
  logic [15:0] m_addr;
  logic        exp_rd;
  logic [26:0] obs_a, obs_b, exp_a, exp_b;

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = 16'h0000;
    for (int i = 0; i < 8; i++) hist[i] = {8'h00, 1'b1, 1'b1};
  endtask

  // Apply one pixel, advance one clock, capture observed and expected outputs.
  task automatic step(input logic [10:0] xi, input logic [10:0] yi,
                      input logic bi, input logic hsi, input logic vsi);
    logic        win;
    logic [15:0] a, w;
    logic [3:0]  p;
    logic [7:0]  c;
    win = bi && (xi <= 11'd639) && (yi >= 11'd80) && (yi <= 11'd479);
    if ((xi <= 11'd639) && (yi >= 11'd80) && (yi <= 11'd479)) begin
      a = 16'((int'(yi) - 80) * 40 + int'(xi) / 16);
      p = 4'(int'(xi) % 16);
    end else begin
      a = 16'($urandom);
      p = 4'($urandom);
    end
    x = xi; y = yi; bright = bi; hsync_in = hsi; vsync_in = vsi;
    address = a; position = p;
    exp_rd = win && (!m_valid || (a != m_addr));
    if (exp_rd) begin
      m_valid = 1'b1;
      m_addr  = a;
    end else if (!win) begin
      m_valid = 1'b0;
    end
    w = fb[a];
    if (win) c = w[4'd15 - p] ? 8'hFF : 8'h00;
    else     c = bi ? 8'h03 : 8'h00;
    hist[n % 8] = {c, hsi, vsi};
    @(posedge clk);
    @(negedge clk);
    obs_a = {mif1.mem_rd_en, mif1.mem_addr, rgb1, hs1, vs1};
    obs_b = {mif3.mem_rd_en, mif3.mem_addr, rgb3, hs3, vs3};
    exp_a = {exp_rd, m_addr, hist[(n + 6) % 8]};
    exp_b = {exp_rd, m_addr, hist[(n + 4) % 8]};
    n++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 11'd0; y = 11'd0; bright = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    address = 16'h0000; position = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    obs_a = {mif1.mem_rd_en, mif1.mem_addr, rgb1, hs1, vs1};
    obs_b = {mif3.mem_rd_en, mif3.mem_addr, rgb3, hs3, vs3};
    vectors += 2;
    if (obs_a !== {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset lat1 got=%h want=%h", obs_a, {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
    end
    if (obs_b !== {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset lat3 got=%h want=%h", obs_b, {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
    end
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    fb[0] = 16'h8001;
    fb[1] = 16'hFFFF;
    step(11'd700, 11'd79, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) step(11'(i), 11'd80, 1'b1, 1'($urandom), 1'($urandom));
      else        step(11'd700, 11'd80, 1'b0, 1'($urandom), 1'($urandom));
      vectors += 2;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL sweep lat1 n=%0d got=%h want=%h", n, obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL sweep lat3 n=%0d got=%h want=%h", n, obs_b, exp_b);
      end
    end
  endtask

  task automatic test_edges();
    int xs [10] = '{638, 639, 640, 641, 5, 700, 0, 1, 700, 700};
    int ys [10] = '{80, 80, 80, 80, 79, 79, 80, 80, 80, 80};
    int bs [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    fb[39] = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      step(11'(xs[i]), 11'(ys[i]), 1'(bs[i]), 1'($urandom), 1'($urandom));
      vectors += 2;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL edges lat1 x=%0d y=%0d got=%h want=%h", xs[i], ys[i], obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL edges lat3 x=%0d y=%0d got=%h want=%h", xs[i], ys[i], obs_b, exp_b);
      end
    end
  endtask

  task automatic test_addresses();
    int xs [8] = '{0, 639, 400, 401, 700, 700, 700, 700};
    int ys [8] = '{89, 479, 200, 200, 300, 300, 300, 300};
    for (int i = 0; i < 8; i++) begin
      step(11'(xs[i]), 11'(ys[i]), 1'(xs[i] < 640), 1'b1, 1'b0);
      vectors += 2;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL addresses lat1 x=%0d y=%0d got=%h want=%h", xs[i], ys[i], obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL addresses lat3 x=%0d y=%0d got=%h want=%h", xs[i], ys[i], obs_b, exp_b);
      end
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        vectors += 2;
        if ({mif1.mem_rd_en, mif1.mem_addr, rgb1, hs1, vs1} !== {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1}) begin
          errors++; $display("FAIL midreset lat1 got=%h want=%h", {mif1.mem_rd_en, mif1.mem_addr, rgb1, hs1, vs1}, {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
        end
        if ({mif3.mem_rd_en, mif3.mem_addr, rgb3, hs3, vs3} !== {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1}) begin
          errors++; $display("FAIL midreset lat3 got=%h want=%h", {mif3.mem_rd_en, mif3.mem_addr, rgb3, hs3, vs3}, {1'b0, 16'h0000, 8'h00, 1'b1, 1'b1});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      step(11'(i), 11'd81, 1'b1, 1'($urandom), 1'($urandom));
      vectors += 2;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL midreset_run lat1 x=%0d got=%h want=%h", i, obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL midreset_run lat3 x=%0d got=%h want=%h", i, obs_b, exp_b);
      end
    end
  endtask

  task automatic test_random();
    int yi, x0, len, xi;
    logic bi;
    for (int r = 0; r < 40; r++) begin
      yi  = $urandom_range(60, 500);
      x0  = $urandom_range(0, 700);
      len = $urandom_range(1, 40);
      for (int k = 0; k <= len; k++) begin
        xi = (k == len) ? 780 : x0 + k;
        if (xi < 640 && yi < 480) bi = ($urandom_range(0, 7) != 0);
        else                      bi = 1'($urandom);
        step(11'(xi), 11'(yi), bi, 1'($urandom), 1'($urandom));
        vectors += 2;
        if (obs_a !== exp_a) begin
          errors++; $display("FAIL random lat1 x=%0d y=%0d got=%h want=%h", xi, yi, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          errors++; $display("FAIL random lat3 x=%0d y=%0d got=%h want=%h", xi, yi, obs_b, exp_b);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(11'd790, 11'd500, 1'b0, 1'b1, 1'b1);
      vectors += 2;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL flush lat1 got=%h want=%h", obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL flush lat3 got=%h want=%h", obs_b, exp_b);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) fb[i] = 16'($urandom);
    test_reset();
    test_sweep();
    test_edges();
    test_addresses();
    test_midframe_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Downstream consumer of the framebuffer address mapper. Each clock it takes one pixel coordinate, that pixel's word address and bit position, and the raw sync/blank from the VGA timing generator. It reads the 16-bit framebuffer word from synchronous memory, selects the addressed bit and drives a colour plus delay-matched syncs to the DAC. Active window: x 0..639, y 80..479, at 16 pixels per word.

Parameters:
MEM_LATENCY, 1, cycles from mem_rd_en/mem_addr to valid mem_data (1..4)
Y_TOP, 80, first active framebuffer line
Y_BOT, 479, last active framebuffer line
X_MAX, 639, last active column
FG_COLOR, 8'hFF, RGB332 colour for a set bit
BG_COLOR, 8'h00, RGB332 colour for a clear bit
BORDER_COLOR, 8'h03, RGB332 colour for bright pixels outside the window

Ports:
clk  in  1  pixel clock, one pixel per cycle
reset  in  1  asynchronous, active-high
x  in  11  current column from timing generator
y  in  11  current row from timing generator
bright  in  1  timing generator visible-area flag
hsync_in  in  1  active-low hsync from timing generator
vsync_in  in  1  active-low vsync from timing generator
address  in  16  framebuffer word address from mapper, (y-Y_TOP)*40 + x/16
position  in  4  bit index within word from mapper, x%16
mem_addr  out  16  framebuffer read address
mem_rd_en  out  1  read strobe
mem_data  in  16  read data, valid MEM_LATENCY cycles after strobe
rgb  out  8  registered pixel colour
hsync_out  out  1  hsync delayed to match rgb
vsync_out  out  1  vsync delayed to match rgb

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high and clears every register.
- Reset values: rgb=0, hsync_out=1, vsync_out=1, mem_rd_en=0, mem_addr=0, word buffer=0, last_addr_valid=0, all pipeline stages inactive.
- Window test, combinational on inputs: in_win = bright && x<=X_MAX && y>=Y_TOP && y<=Y_BOT.
- Fetch stage (cycle 0):
  - When in_win and (!last_addr_valid || address!=last_addr): assert mem_rd_en, drive mem_addr=address, register last_addr=address, set last_addr_valid=1.
  - Otherwise mem_rd_en=0 and mem_addr holds its value.
  - Result: at most one read per 16-pixel word.
- Read-suppression reset: last_addr_valid clears whenever in_win=0, so the first pixel of every line and frame always fetches, even if the address repeats.
- Delay line, MEM_LATENCY+1 stages deep, carries position, in_win, fetched flag, hsync_in and vsync_in.
- Word buffer: when the delayed fetched flag is 1, load the buffer from mem_data. The selected word is mem_data on that cycle and the buffer otherwise.
- Bit select: position 0 selects bit 15 (MSB is the leftmost pixel) and position 15 selects bit 0.
- Output stage (registered):
  - rgb = delayed in_win ? (bit ? FG_COLOR : BG_COLOR) : (delayed bright ? BORDER_COLOR : 8'h00).
- Latency: any input at cycle N appears on rgb/hsync_out/vsync_out at cycle N+MEM_LATENCY+1, fixed and independent of whether a fetch occurred.
- Boundary conditions:
  - x=X_MAX→X_MAX+1: window closes and the next line refetches.
  - y=Y_TOP-1→Y_TOP: first fetch at address 0.
  - address wraps within 16 bits; never exceeds 15999 in legal use.
  - Mapper output outside the window is ignored, with no read issued.
- Reset mid-frame: pipeline flushes immediately. Outputs return to reset values asynchronously. After deassert, the first valid rgb appears MEM_LATENCY+1 cycles after the first in_win pixel.
- Simultaneous window exit and pending read: the read still completes and its data is discarded by the delayed in_win=0.

Test Plan:
1. Reset asserted mid-line with MEM_LATENCY=1 -> rgb=0, hsync_out=1, vsync_out=1, mem_rd_en=0 on the same edge; outputs resume 2 cycles after first in_win.
2. Sweep x=0..31, y=80 (addr 0/1, pos 0..15) with memory word0=16'h8001, word1=16'hFFFF -> mem_rd_en pulses only at x=0 and x=16. rgb: FF at x=0, 00 for x=1..14, FF at x=15 and x=16..31; each appears 2 cycles later.
3. x=639,y=80 (addr 39,pos 15), word39=16'h0001 -> rgb=FF. Next pixel x=640 gives BORDER_COLOR 8'h03 if bright, else 00.
4. x=0,y=89 (addr 360); x=639,y=479 (addr 15999,pos 15); x=400,y=200 (addr 4825,pos 0) -> mem_addr equals each value and the pixel follows the memory contents.
5. y=79 with bright=1 -> no mem_rd_en, rgb=8'h03. y=80 at x=0 -> fetch issued even though last_addr was 0 from the previous frame.
6. MEM_LATENCY=3 rerun of scenario 2 -> same rgb sequence shifted to 4 cycles; hsync_out/vsync_out edges stay aligned with rgb.
